// File: rtl/queue_rr_scheduler.sv
// rtl/queue_rr_scheduler.sv - round-robin write arbiter, read sequencer and occupancy counter for one queue
// Producers share the queue write port; the read side presents a registered valid/ready stream.
module queue_rr_scheduler #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 3,
  parameter int NUM_REQ       = 4,
  parameter int REQ_IDX_WIDTH = 2
) (
  input  logic                          sclk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          q_full,
  input  logic                          q_empty,
  output logic                          q_write_en,
  output logic [DATA_WIDTH-1:0]         q_data_in,
  output logic                          q_read_en,
  input  logic [DATA_WIDTH-1:0]         q_data_out,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [ADDRESS_WIDTH:0]        level
);

  localparam int DEPTH   = 1 << ADDRESS_WIDTH;
  localparam int PAD_REQ = 1 << REQ_IDX_WIDTH;
  localparam logic [ADDRESS_WIDTH:0]   LEVEL_MAX = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [REQ_IDX_WIDTH:0]   NUM_REQ_X = (REQ_IDX_WIDTH+1)'(NUM_REQ);
  localparam logic [REQ_IDX_WIDTH-1:0] LAST_IDX  = REQ_IDX_WIDTH'(NUM_REQ-1);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_HOLD  = 2'd2
  } rd_state_t;

  rd_state_t rd_state, rd_state_next;

  logic [REQ_IDX_WIDTH-1:0] rr_ptr;
  logic [REQ_IDX_WIDTH-1:0] gnt_idx;
  logic [REQ_IDX_WIDTH:0]   cand;
  logic [PAD_REQ-1:0]       valid_pad;
  logic                     gnt_found;
  logic                     can_write;

  // Search from rr_ptr upward, wrapping at NUM_REQ; padded slots never win.
  always_comb begin
    valid_pad                = '0;
    valid_pad[NUM_REQ-1:0]   = req_valid;
    gnt_found                = 1'b0;
    gnt_idx                  = '0;
    cand                     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (REQ_IDX_WIDTH+1)'(k);
      if (cand >= NUM_REQ_X) begin
        cand = cand - NUM_REQ_X;
      end
      if (!gnt_found && valid_pad[cand[REQ_IDX_WIDTH-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[REQ_IDX_WIDTH-1:0];
      end
    end
  end

  assign can_write  = gnt_found & ~q_full;
  assign q_write_en = can_write;

  always_comb begin
    req_ready = '0;
    q_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (can_write && (gnt_idx == REQ_IDX_WIDTH'(i))) begin
        req_ready[i] = 1'b1;
        q_data_in    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (can_write) begin
      rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Queue read data lands one cycle after q_read_en, so every pop passes through R_FETCH.
  always_comb begin
    rd_state_next = rd_state;
    q_read_en     = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (!q_empty) begin
          q_read_en     = 1'b1;
          rd_state_next = R_FETCH;
        end
      end
      R_FETCH: begin
        rd_state_next = R_HOLD;
      end
      R_HOLD: begin
        if (rd_ready) begin
          if (!q_empty) begin
            q_read_en     = 1'b1;
            rd_state_next = R_FETCH;
          end else begin
            rd_state_next = R_IDLE;
          end
        end
      end
      default: begin
        rd_state_next = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      rd_state <= R_IDLE;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_state <= rd_state_next;
      if (rd_state == R_FETCH) begin
        rd_data  <= q_data_out;
        rd_valid <= 1'b1;
      end else if (rd_state == R_HOLD && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      level <= '0;
    end else begin
      case ({q_write_en, q_read_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // The counter must track the queue's own flags exactly.
  assert property (@(posedge sclk) disable iff (reset) q_full == (level == LEVEL_MAX))
    else $error("queue_rr_scheduler: level %0d disagrees with q_full", level);
  assert property (@(posedge sclk) disable iff (reset) q_empty == (level == '0))
    else $error("queue_rr_scheduler: level %0d disagrees with q_empty", level);
  assert property (@(posedge sclk) disable iff (reset) level <= LEVEL_MAX)
    else $error("queue_rr_scheduler: level %0d above depth", level);

endmodule

// File: tb/tb_queue_rr_scheduler.sv
// tb/tb_queue_rr_scheduler.sv - bench for queue_rr_scheduler with a behavioural queue and data scoreboard
module tb_queue_rr_scheduler;

  localparam int DW = 64;

  logic          sclk = 1'b0;
  logic          reset;
  logic [3:0]    req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]    req_ready;
  logic          q_full, q_empty, q_write_en, q_read_en;
  logic [DW-1:0] q_data_in, q_data_out, rd_data;
  logic          rd_valid, rd_ready;
  logic [3:0]    level;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  bit prev_hs = 1'b0;

  always #5 sclk = ~sclk;

  queue_rr_scheduler #(
    .DATA_WIDTH(64), .ADDRESS_WIDTH(3), .NUM_REQ(4), .REQ_IDX_WIDTH(2)
  ) dut (
    .sclk(sclk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .q_full(q_full), .q_empty(q_empty),
    .q_write_en(q_write_en), .q_data_in(q_data_in),
    .q_read_en(q_read_en), .q_data_out(q_data_out),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level)
  );

  // Depth-8 queue with registered read data
  logic [DW-1:0] mem [8];
  logic [2:0] wp, rp;
  logic [3:0] cnt;
  logic do_wr, do_rd;
  assign q_full  = (cnt == 4'd8);
  assign q_empty = (cnt == 4'd0);
  assign do_wr   = q_write_en && !q_full;
  assign do_rd   = q_read_en && !q_empty;

  always @(posedge sclk) begin
    if (reset) begin
      wp <= '0; rp <= '0; cnt <= '0; q_data_out <= '0;
    end else begin
      if (do_wr) begin mem[wp] <= q_data_in; wp <= wp + 3'd1; end
      if (do_rd) begin q_data_out <= mem[rp]; rp <= rp + 3'd1; end
      cnt <= cnt + {3'b0, do_wr} - {3'b0, do_rd};
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: push on producer transfer, pop on consumer handshake
  always @(negedge sclk) begin
    if (reset) begin
      prev_hs = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) exp_q.push_back(req_data[i*DW +: DW]);
      if (rd_valid && rd_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got %0h, expected no entry", rd_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL sb_data: got %0h, expected %0h", rd_data, e);
          end
        end
      end
      if (prev_hs) chk("rd_valid_in_fetch", 64'(rd_valid), 64'(0));
      chk("read_while_empty", 64'(q_read_en && q_empty), 64'(0));
      prev_hs = rd_valid && rd_ready;
    end
  end

  typedef struct {
    logic [3:0]    valid;
    logic [3:0]    exp_ready;
    logic          exp_we;
    logic [DW-1:0] exp_data;
  } vec_t;
  vec_t tbl[$];

  task automatic cyc();
    @(posedge sclk);
    #1;
  endtask

  task automatic std_data();
    for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 64'(i*256 + 1);
  endtask

  task automatic run_vec(input int n);
    req_valid = tbl[n].valid;
    @(negedge sclk);
    chk($sformatf("req_ready[%0d]", n), 64'(req_ready), 64'(tbl[n].exp_ready));
    chk($sformatf("q_write_en[%0d]", n), 64'(q_write_en), 64'(tbl[n].exp_we));
    chk($sformatf("q_data_in[%0d]", n), q_data_in, tbl[n].exp_data);
    cyc();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bit done = 1'b0;
    req_valid = '0;
    rd_ready  = 1'b1;
    while (!done && n < 60) begin
      @(negedge sclk);
      if (exp_q.size() == 0 && !rd_valid && level == 4'd0) done = 1'b1;
      else begin cyc(); n++; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got level %0d, expected drained queue", tag, level);
    end
    chk({tag, "_level"}, 64'(level), 64'(0));
    chk({tag, "_read_en"}, 64'(q_read_en), 64'(0));
    cyc();
    rd_ready = 1'b0;
  endtask

  initial begin
    // Table 1: four held producers filling the queue; Table 2: pointer wrap cases
    tbl.push_back('{4'hF, 4'h1, 1'b1, 64'd1});
    tbl.push_back('{4'hF, 4'h2, 1'b1, 64'd257});
    tbl.push_back('{4'hF, 4'h4, 1'b1, 64'd513});
    tbl.push_back('{4'hF, 4'h8, 1'b1, 64'd769});
    tbl.push_back('{4'hF, 4'h1, 1'b1, 64'd1});
    tbl.push_back('{4'hF, 4'h2, 1'b1, 64'd257});
    tbl.push_back('{4'hF, 4'h4, 1'b1, 64'd513});
    tbl.push_back('{4'hF, 4'h8, 1'b1, 64'd769});
    tbl.push_back('{4'hF, 4'h1, 1'b1, 64'd1});
    tbl.push_back('{4'hF, 4'h0, 1'b0, 64'd0});
    tbl.push_back('{4'h4, 4'h4, 1'b1, 64'd513});
    tbl.push_back('{4'h4, 4'h4, 1'b1, 64'd513});
    tbl.push_back('{4'hF, 4'h8, 1'b1, 64'd769});
    tbl.push_back('{4'h5, 4'h1, 1'b1, 64'd1});

    reset = 1'b1; req_valid = '0; rd_ready = 1'b0; req_data = '0;
    repeat (2) cyc();
    reset = 1'b0;
    @(negedge sclk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_write_en", 64'(q_write_en), 64'(0));
    chk("rst_read_en", 64'(q_read_en), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    cyc();

    std_data();
    for (int n = 0; n < 10; n++) run_vec(n);
    req_valid = '0;
    @(negedge sclk);
    chk("fill_level", 64'(level), 64'(8));
    chk("fill_rd_valid", 64'(rd_valid), 64'(1));
    chk("fill_rd_data", rd_data, 64'd1);
    chk("fill_read_en", 64'(q_read_en), 64'(0));
    cyc();

    // Full queue: consumer pop frees a slot, producer 1 refills it
    rd_ready = 1'b1; req_valid = 4'h2; req_data[DW +: DW] = 64'h1111;
    @(negedge sclk);
    chk("full_req_ready", 64'(req_ready), 64'(0));
    chk("full_read_en", 64'(q_read_en), 64'(1));
    cyc();
    @(negedge sclk);
    chk("refill_req_ready", 64'(req_ready), 64'(4'h2));
    chk("refill_data", q_data_in, 64'h1111);
    chk("refill_rd_valid", 64'(rd_valid), 64'(0));
    cyc();
    req_valid = '0; rd_ready = 1'b0;
    @(negedge sclk);
    chk("refill_level", 64'(level), 64'(8));
    chk("refill_rd_data", rd_data, 64'd257);
    cyc();
    drain("drain_full");

    // Single producer pushes boundary values, then consumer drains
    foreach (tbl[0].exp_data[k]) begin end
    begin
      logic [DW-1:0] vals [4];
      vals[0] = 64'd1; vals[1] = 64'd256; vals[2] = 64'd3325; vals[3] = 64'd0;
      for (int k = 0; k < 4; k++) begin
        req_valid = 4'h1; req_data[0 +: DW] = vals[k];
        @(negedge sclk);
        chk($sformatf("push_ready[%0d]", k), 64'(req_ready), 64'(4'h1));
        chk($sformatf("push_data[%0d]", k), q_data_in, vals[k]);
        cyc();
      end
    end
    drain("drain_push");

    std_data();
    for (int n = 10; n < 14; n++) run_vec(n);
    req_valid = '0;
    @(negedge sclk);
    chk("hold_level", 64'(level), 64'(3));
    chk("hold_rd_valid", 64'(rd_valid), 64'(1));
    cyc();

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    @(negedge sclk);
    chk("midrst_rd_valid", 64'(rd_valid), 64'(0));
    chk("midrst_level", 64'(level), 64'(0));
    chk("midrst_rd_data", rd_data, 64'd0);
    chk("midrst_read_en", 64'(q_read_en), 64'(0));
    cyc();
    req_valid = 4'hF;
    @(negedge sclk);
    chk("midrst_rr_ptr", 64'(req_ready), 64'(4'h1));
    cyc();
    req_valid = '0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
